// File: rtl/ber_monitor.sv
// ber_monitor: finds the tx-to-rx latency by delay search, then counts per-frame and cumulative bit errors
module ber_monitor #(
    parameter int MAX_DELAY   = 128,
    parameter int WINDOW      = 32,
    parameter int LOCK_THRESH = 2,
    parameter int FRAME_LEN   = 256,
    parameter int LOSS_THRESH = 32,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         tx_bit,
    input  logic                         rx_bit,
    output logic                         locked,
    output logic [$clog2(MAX_DELAY)-1:0] delay,
    output logic                         frame_done,
    output logic [CNT_W-1:0]             frame_errors,
    output logic [31:0]                  total_bits,
    output logic [31:0]                  total_errors
);
    localparam int WW = $clog2(WINDOW + 1);
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t               state;
    logic [MAX_DELAY-2:0] hist;
    logic [MAX_DELAY-1:0] taps;
    logic [WW-1:0]        win_cnt, win_err, win_sum;
    logic [CNT_W-1:0]     frame_cnt, frame_err, frame_sum;
    logic                 mis;
    // taps[d] is the tx bit presented d enables ago; taps[0] is the live bit
    assign taps = {hist, tx_bit};
    always_comb begin
        mis       = rx_bit ^ taps[delay];
        win_sum   = win_err + WW'(mis);
        frame_sum = frame_err + CNT_W'(mis);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            hist         <= '0;
            win_cnt      <= '0;
            win_err      <= '0;
            frame_cnt    <= '0;
            frame_err    <= '0;
            locked       <= 1'b0;
            delay        <= '0;
            frame_done   <= 1'b0;
            frame_errors <= '0;
            total_bits   <= '0;
            total_errors <= '0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                hist <= taps[MAX_DELAY-2:0];
                if (state == SEARCH) begin
                    if (win_cnt == WW'(WINDOW - 1)) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_sum <= WW'(LOCK_THRESH)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            delay <= delay + 1'b1;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        win_err <= win_sum;
                    end
                end else begin
                    total_bits   <= total_bits + 32'(total_bits != '1);
                    total_errors <= total_errors + 32'(mis && total_errors != '1);
                    if (frame_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        frame_cnt    <= '0;
                        frame_err    <= '0;
                        frame_errors <= frame_sum;
                        frame_done   <= 1'b1;
                        if (frame_sum > CNT_W'(LOSS_THRESH)) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            delay  <= '0;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                        frame_err <= frame_sum;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: directed checks of search, lock, frame counting, loss, strobe gaps, wrap and async reset
module tb_ber_monitor;
    logic        clk = 0, reset = 0, en = 0, tx_bit = 0, rx_bit = 0;
    logic        locked, frame_done;
    logic [6:0]  delay;
    logic [15:0] frame_errors;
    logic [31:0] total_bits, total_errors;
    logic [14:0] lfsr = 15'h1;
    bit          ring [256];
    bit          inv = 0;
    int          n = 0, dly = 37, n_checks = 0, n_fail = 0;

    ber_monitor dut (
        .clk(clk), .reset(reset), .en(en), .tx_bit(tx_bit), .rx_bit(rx_bit),
        .locked(locked), .delay(delay), .frame_done(frame_done),
        .frame_errors(frame_errors), .total_bits(total_bits), .total_errors(total_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // channel model: rx is tx delayed by dly enables, optionally inverted or flipped
    task automatic step(input bit e, input bit flip);
        en = e;
        if (e) begin
            tx_bit = lfsr[14];
            lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            rx_bit = (dly == 0 ? tx_bit : ring[(n - dly) & 255]) ^ inv ^ flip;
            ring[n & 255] = tx_bit;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cnt, input int nflip, input bit gap);
        for (int i = 0; i < cnt; i++) begin
            if (gap) step(0, 0);
            step(1, i < nflip);
        end
    endtask

    task automatic restart_chan();
        n = 0;
        for (int i = 0; i < 256; i++) ring[i] = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_delay"}, delay, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_ferr"}, frame_errors, 0);
        check({tag, "_tbits"}, total_bits, 0);
        check({tag, "_terr"}, total_errors, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1;
        restart_chan();
        run(1215, 0, 0);
        check("prelock_locked", locked, 0);
        check("prelock_delay", delay, 37);
        run(1, 0, 0);
        check("lock_locked", locked, 1);
        check("lock_delay", delay, 37);
        check("lock_tbits", total_bits, 0);
        run(255, 0, 0);
        check("f1_early_fdone", frame_done, 0);
        run(1, 0, 0);
        check("f1_fdone", frame_done, 1);
        check("f1_ferr", frame_errors, 0);
        check("f1_tbits", total_bits, 256);
        run(1, 0, 0);
        check("f1_pulse_width", frame_done, 0);
        run(255, 0, 0);
        check("f2_tbits", total_bits, 512);
        run(256, 5, 0);
        check("f3_fdone", frame_done, 1);
        check("f3_ferr", frame_errors, 5);
        check("f3_terr", total_errors, 5);
        check("f3_tbits", total_bits, 768);
        run(256, 0, 0);
        check("f4_ferr", frame_errors, 0);
        check("f4_terr", total_errors, 5);
        run(256, 40, 0);
        check("loss_fdone", frame_done, 1);
        check("loss_ferr", frame_errors, 40);
        check("loss_locked", locked, 0);
        check("loss_delay", delay, 0);
        check("loss_terr", total_errors, 45);
        check("loss_tbits", total_bits, 1280);
        run(1215, 0, 0);
        check("relock_pre_locked", locked, 0);
        check("relock_pre_tbits", total_bits, 1280);
        run(1, 0, 0);
        check("relock_locked", locked, 1);
        check("relock_delay", delay, 37);
        check("relock_terr", total_errors, 45);
        run(100, 0, 0);
        reset = 0;
        #1;
        check_zero("async");
        en = 0;
        @(posedge clk);
        #1;
        reset = 1;
        dly = 5;
        restart_chan();
        check("restart_delay", delay, 0);
        run(191, 0, 1);
        check("gap_pre_locked", locked, 0);
        check("gap_pre_delay", delay, 5);
        run(1, 0, 1);
        check("gap_locked", locked, 1);
        check("gap_delay", delay, 5);
        run(255, 0, 1);
        step(0, 0);
        check("gap_idle_fdone", frame_done, 0);
        check("gap_mid_tbits", total_bits, 255);
        step(1, 0);
        check("gap_fdone", frame_done, 1);
        check("gap_tbits", total_bits, 256);
        step(0, 0);
        check("gap_after_fdone", frame_done, 0);
        check("gap_ferr_held", frame_errors, 0);
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        dly = 0;
        inv = 1;
        restart_chan();
        run(32, 0, 0);
        check("wrap_first_step", delay, 1);
        run(4063, 0, 0);
        check("wrap_last_delay", delay, 127);
        run(1, 0, 0);
        check("wrap_delay", delay, 0);
        check("wrap_locked", locked, 0);
        check("wrap_tbits", total_bits, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
